// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory access sequencer for the Mini SRC CPU.
// Arbitrates between instruction fetch and data load/store requesters and
// drives the MAR/MDR/RAM strobes through IDLE -> ADDR -> [WDATA] -> ACCESS
// -> [LATCH] -> DONE. Ties go round-robin, starting with fetch after reset.
//
// Ports:
//   Clock      in   system clock, rising edge
//   Clear      in   asynchronous reset, active-low
//   fetch_req  in   fetch read request (level, held until fetch_ack)
//   data_req   in   data access request (level, held until data_ack)
//   data_we    in   1 = store, 0 = load; sampled with data_req
//   mem_ready  in   RAM access complete; only looked at in ACCESS
//   grant_data out  bus owner: 0 = fetch, 1 = data (valid ADDR..DONE)
//   busy       out  high in every state except IDLE
//   MARin      out  MAR load strobe
//   MDRin      out  MDR load enable
//   Read       out  MDR source select and RAM read strobe
//   Write      out  RAM write strobe
//   fetch_ack  out  one-cycle completion pulse to fetch
//   data_ack   out  one-cycle completion pulse to data
//   err        out  timeout flag, high with the ack (MEM_TIMEOUT_EN only)
//
// Optional feature macro: MEM_TIMEOUT_EN. When defined, ACCESS gives up after
// MAX_WAIT cycles without mem_ready and finishes with err. When undefined,
// there is no wait counter and no err port; ACCESS waits indefinitely.
module mem_access_ctrl #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CW       = 5
) (
    input  logic Clock,
    input  logic Clear,
    input  logic fetch_req,
    input  logic data_req,
    input  logic data_we,
    input  logic mem_ready,
    output logic grant_data,
    output logic busy,
    output logic MARin,
    output logic MDRin,
    output logic Read,
    output logic Write,
    output logic fetch_ack,
    output logic data_ack
`ifdef MEM_TIMEOUT_EN
    ,
    output logic err
`endif
);

    // The wait counter must be able to hold MAX_WAIT.
    if (MAX_WAIT >= (1 << CW)) begin : g_bad_cfg
        $error("mem_access_ctrl: CW too narrow for MAX_WAIT");
    end

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWdata,
        StAccess,
        StLatch,
        StDone
    } state_e;

    state_e state_q, state_d;
    logic   op_q, op_d;        // 1 = write
    logic   owner_q, owner_d;  // 1 = data requester
    logic   last_q, last_d;    // owner of the last completed transaction

`ifdef MEM_TIMEOUT_EN
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          timeout;

    // cnt_q counts ACCESS cycles already spent; this is the MAX_WAIT-th one.
    assign timeout = (cnt_q == CW'(MAX_WAIT - 1)) && !mem_ready;
`endif

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= StIdle;
            op_q    <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;  // fetch wins the first tie
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            owner_q <= owner_d;
            last_q  <= last_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        owner_d = owner_q;
        last_d  = last_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (fetch_req || data_req) begin
                    owner_d = (fetch_req && data_req) ? ~last_q : data_req;
                    op_d    = owner_d ? data_we : 1'b0;
                    state_d = StAddr;
                end
            end
            StAddr:  state_d = op_q ? StWdata : StAccess;
            StWdata: state_d = StAccess;
            StAccess: begin
`ifdef MEM_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (mem_ready) begin
                    state_d = op_q ? StDone : StLatch;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (timeout) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    err_d   = 1'b1;
`endif
                end
            end
            StLatch: state_d = StDone;
            StDone: begin
                last_d  = owner_q;
                state_d = StIdle;
`ifdef MEM_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs; an async Clear forces StIdle, so every strobe drops at once.
    always_comb begin
        busy       = 1'b0;
        grant_data = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        Read       = 1'b0;
        Write      = 1'b0;
        fetch_ack  = 1'b0;
        data_ack   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        err        = 1'b0;
`endif
        if (state_q != StIdle) begin
            busy       = 1'b1;
            grant_data = owner_q;
        end
        case (state_q)
            StAddr:   MARin = 1'b1;
            StWdata:  MDRin = 1'b1;
            StAccess: begin
                Read  = ~op_q;
                Write = op_q;
            end
            StLatch: begin
                MDRin = 1'b1;
                Read  = 1'b1;
            end
            StDone: begin
                fetch_ack = ~owner_q;
                data_ack  = owner_q;
`ifdef MEM_TIMEOUT_EN
                err       = err_q;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. Expected acks (owner, cycle, err)
// are queued when a request is driven and popped when an ack appears.
module tb_mem_access_ctrl;

    logic Clock = 1'b0;
    logic Clear;
    logic fetch_req, data_req, data_we, mem_ready;
    logic grant_data, busy, MARin, MDRin, Read, Write, fetch_ack, data_ack;
`ifdef MEM_TIMEOUT_EN
    logic err;
`endif

    mem_access_ctrl #(
        .MAX_WAIT(4),
        .CW      (5)
    ) dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .fetch_req (fetch_req),
        .data_req  (data_req),
        .data_we   (data_we),
        .mem_ready (mem_ready),
        .grant_data(grant_data),
        .busy      (busy),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .Read      (Read),
        .Write     (Write),
        .fetch_ack (fetch_ack),
        .data_ack  (data_ack)
`ifdef MEM_TIMEOUT_EN
        ,
        .err       (err)
`endif
    );

    always #5 Clock = ~Clock;

    int unsigned cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic        is_data;
        int unsigned at_cyc;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic is_data, input int unsigned at_cyc, input logic e);
        exp_t x;
        x.is_data = is_data;
        x.at_cyc  = at_cyc;
        x.err     = e;
        sb_q.push_back(x);
    endtask

    // Scoreboard pop plus strobe exclusivity, sampled mid-cycle.
    always @(negedge Clock) begin
        if (Clear) begin
            check("mdrin_write_excl", 32'(MDRin & Write), 0);
            check("read_write_excl", 32'(Read & Write), 0);
            if (fetch_ack || data_ack) begin
                check("ack_expected", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    exp_t x;
                    x = sb_q.pop_front();
                    check("ack_both", 32'(fetch_ack & data_ack), 0);
                    check("ack_owner", 32'(data_ack), 32'(x.is_data));
                    check("ack_cycle", cyc, x.at_cyc);
`ifdef MEM_TIMEOUT_EN
                    check("ack_err", 32'(err), 32'(x.err));
`endif
                end
            end
        end
    end

    function automatic logic [7:0] outs();
        return {busy, grant_data, MARin, MDRin, Read, Write, fetch_ack, data_ack};
    endfunction

    initial begin
        int unsigned e;
        Clear     = 1'b0;
        fetch_req = 1'b0;
        data_req  = 1'b0;
        data_we   = 1'b0;
        mem_ready = 1'b0;
        tick();
        tick();
        check("reset_outs", 32'(outs()), 0);
        Clear = 1'b1;
        tick();
        check("idle_outs", 32'(outs()), 0);

        // Load, no waits; mem_ready high outside ACCESS is ignored.
        e = cyc;
        fetch_req = 1'b1;
        mem_ready = 1'b1;
        push(1'b0, e + 4, 1'b0);
        tick();
        check("ld_addr", 32'(outs()), 32'b1_0_1_0_0_0_0_0);
        tick();
        check("ld_access", 32'(outs()), 32'b1_0_0_0_1_0_0_0);
        tick();
        check("ld_latch", 32'(outs()), 32'b1_0_0_1_1_0_0_0);
        tick();
        check("ld_done", 32'(outs()), 32'b1_0_0_0_0_0_1_0);
        fetch_req = 1'b0;
        tick();
        check("ld_idle", 32'(outs()), 0);

        // Store with mem_ready on the 3rd ACCESS cycle.
        e = cyc;
        mem_ready = 1'b0;
        data_req  = 1'b1;
        data_we   = 1'b1;
        push(1'b1, e + 6, 1'b0);
        tick();
        check("st_addr", 32'(outs()), 32'b1_1_1_0_0_0_0_0);
        tick();
        check("st_wdata", 32'(outs()), 32'b1_1_0_1_0_0_0_0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_access", 32'(outs()), 32'b1_1_0_0_0_1_0_0);
        end
        mem_ready = 1'b1;
        tick();
        check("st_done", 32'(outs()), 32'b1_1_0_0_0_0_0_1);
        data_req = 1'b0;
        data_we  = 1'b0;
        tick();
        check("st_idle", 32'(busy), 0);

        // Tie: last served was data, so fetch, data, fetch.
        e = cyc;
        fetch_req = 1'b1;
        data_req  = 1'b1;
        push(1'b0, e + 4, 1'b0);
        push(1'b1, e + 9, 1'b0);
        push(1'b0, e + 14, 1'b0);
        for (int i = 1; i <= 14; i++) begin
            tick();
            check("rr_busy", 32'(busy), 32'(i != 5 && i != 10));
            if (i == 1 || i == 6 || i == 11) begin
                check("rr_marin", 32'(MARin), 1);
                check("rr_grant", 32'(grant_data), 32'(i == 6));
            end
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        tick();
        check("rr_idle", 32'(busy), 0);

        // Late data request during fetch ACCESS.
        e = cyc;
        mem_ready = 1'b0;
        fetch_req = 1'b1;
        push(1'b0, e + 5, 1'b0);
        tick();
        tick();
        data_req = 1'b1;
        push(1'b1, e + 10, 1'b0);
        tick();
        check("late_grant", 32'(grant_data), 0);
        mem_ready = 1'b1;
        tick();
        tick();
        check("late_fack", 32'(fetch_ack), 1);
        fetch_req = 1'b0;
        tick();
        check("late_idle", 32'(busy), 0);
        tick();
        check("late_addr", 32'({MARin, grant_data}), 32'b11);
        tick();
        tick();
        tick();
        check("late_dack", 32'(data_ack), 1);
        data_req = 1'b0;
        tick();

        // Async reset during ACCESS: outputs drop before the next edge.
        mem_ready = 1'b0;
        fetch_req = 1'b1;
        tick();
        tick();
        check("rst_in_access", 32'(Read), 1);
        #2;
        Clear     = 1'b0;
        fetch_req = 1'b0;
        #1;
        check("rst_async_outs", 32'(outs()), 0);
        tick();
        tick();
        check("rst_held_outs", 32'(outs()), 0);
        #3;
        Clear = 1'b1;
        tick();
        check("rst_release_idle", 32'(outs()), 0);

`ifdef MEM_TIMEOUT_EN
        // Timeout after MAX_WAIT=4 ACCESS cycles, no LATCH.
        e = cyc;
        mem_ready = 1'b0;
        fetch_req = 1'b1;
        push(1'b0, e + 6, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("to_mdrin", 32'(MDRin), 0);
            check("to_err", 32'(err), 32'(i == 6));
            if (i >= 2 && i <= 5) check("to_access_read", 32'(Read), 1);
        end
        check("to_fack", 32'(fetch_ack), 1);
        fetch_req = 1'b0;
        tick();
        check("to_idle", 32'({busy, err}), 0);
`endif

        tick();
        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences the MAR/MDR/RAM path for the Mini SRC CPU.
- Arbitrates between two requesters, instruction fetch and data load/store, with round-robin on ties.
- Drives the MARin, MDRin, Read and Write strobes and waits on the RAM ready handshake.
- Returns a one-cycle ack to the winning requester; the grant output tells requesters who owns the bus.

Parameters:
- MAX_WAIT, 16, maximum ACCESS cycles waiting for mem_ready before timeout; only used with MEM_TIMEOUT_EN.
- CW, 5, width of the wait counter; must satisfy 2^CW > MAX_WAIT.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Clear  in  1  asynchronous reset, active-low.
- fetch_req  in  1  fetch read request; level, held until fetch_ack.
- data_req  in  1  data access request; level, held until data_ack.
- data_we  in  1  1 = store, 0 = load; sampled with data_req.
- mem_ready  in  1  RAM access complete; meaningful only in ACCESS.
- grant_data  out  1  0 = fetch owns bus, 1 = data owns bus; valid from ADDR to DONE.
- busy  out  1  high in every state except IDLE.
- MARin  out  1  MAR load strobe.
- MDRin  out  1  MDR load enable.
- Read  out  1  MDR source select and RAM read strobe.
- Write  out  1  RAM write strobe.
- fetch_ack  out  1  one-cycle completion pulse to fetch.
- data_ack  out  1  one-cycle completion pulse to data.
- err  out  1  timeout flag qualified by ack; exists only with MEM_TIMEOUT_EN.

Behaviour:
- States: IDLE, ADDR, WDATA, ACCESS, LATCH, DONE. Outputs are Moore-decoded from the state register plus the op/owner registers.
- Reset (Clear=0, async): state=IDLE, op=0, owner=0, last=1 (data last served, so fetch wins the first tie), wait counter=0. All outputs are 0.

IDLE:
- No request: stay in IDLE.
- Only fetch_req: owner=0, op=read.
- Only data_req: owner=1, op=data_we.
- Both requests: owner = ~last; op is read for fetch, data_we for data.
- Any grant goes to ADDR.

ADDR (1 cycle):
- MARin=1; requester drives the address on the bus.
- Next state: WDATA if op=write, else ACCESS.

WDATA (1 cycle):
- MDRin=1, Read=0; MDR loads the store data from the bus.
- Next state: ACCESS.

ACCESS:
- Read = ~op, Write = op; counter increments each cycle spent here.
- mem_ready=1: leave to LATCH if read, DONE if write. The counter clears on exit.
- mem_ready=0: stay in ACCESS.

LATCH (1 cycle):
- MDRin=1, Read=1; MDR loads Mdatain.
- Next state: DONE.

DONE (1 cycle):
- The owner's ack=1, last=owner.
- Next state: IDLE.

Latency and handshake:
- With mem_ready already high on the first ACCESS cycle: read is req to ack = 4 cycles (ADDR, ACCESS, LATCH, DONE); write is 4 cycles (ADDR, WDATA, ACCESS, DONE).
- Each extra wait cycle adds 1.
- A requester drops req in the cycle after its ack. req still high in IDLE after DONE is a new request.
- Requests are only sampled in IDLE. A request arriving mid-transaction waits and gets no grant until DONE→IDLE.
- A request that deasserts mid-transaction does not abort it; ack is still issued.
- mem_ready outside ACCESS is ignored.
- Write and MDRin are never high in the same cycle. Read and Write are never both high.
- Async reset mid-transaction returns to IDLE immediately; no ack is issued and the strobes drop without waiting for a clock.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - In ACCESS, if the counter reaches MAX_WAIT without mem_ready, go straight to DONE, skipping LATCH.
  - In that DONE cycle, err=1 together with the owner's ack. The counter clears and last updates as normal.
  - err is 0 in every other cycle.
- Undefined:
  - The counter and err port do not exist; ACCESS waits indefinitely for mem_ready.

Test Plan:
- Load, no waits: fetch_req=1, mem_ready held 1 → MARin at cycle 1, Read at cycle 2, MDRin+Read at cycle 3, fetch_ack at cycle 4, grant_data=0 throughout.
- Store with waits: data_req=1, data_we=1, mem_ready raised on the 3rd ACCESS cycle → MARin, then MDRin with Read=0, then Write=1 for 3 cycles, then data_ack; total 6 cycles; MDRin never coincident with Write.
- Tie, round-robin: fetch_req and data_req both held for three transactions → grants fetch, data, fetch; acks alternate; busy low exactly one cycle between transactions.
- Late request: data_req rises during fetch ACCESS → no grant change; data ADDR starts 2 cycles after fetch_ack.
- Reset mid-operation: Clear=0 asserted during ACCESS between clock edges → state IDLE and all outputs 0 before the next edge; no ack pulse.
- Timeout (MEM_TIMEOUT_EN, MAX_WAIT=4): fetch_req with mem_ready=0 → 4 ACCESS cycles, then DONE with fetch_ack=1 and err=1; no LATCH/MDRin pulse.
